// File: rtl/round_ctrl.sv
// Round/lives sequencer between the keyboard and the game core: title, countdown, play,
// death blink, respawn and game-over, with registered outputs for the core and overlays.
module round_ctrl #(
   parameter int          FPS             = 60,
   parameter int          COUNT_SECS      = 3,
   parameter int          DIE_FRAMES      = 64,
   parameter int          LIVES_INIT      = 3,
   parameter int          GAMEOVER_FRAMES = 600,
   parameter logic [7:0]  START_KEY       = 8'h28
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic       over,
   input  logic [7:0] keycode,
   output logic       game_reset,
   output logic [7:0] keycode_out,
   output logic [1:0] lives,
   output logic [2:0] round_state,
   output logic [1:0] cd_digit,
   output logic       blink
);

   localparam logic [2:0] S_TITLE     = 3'd0;
   localparam logic [2:0] S_COUNTDOWN = 3'd1;
   localparam logic [2:0] S_PLAYING   = 3'd2;
   localparam logic [2:0] S_DYING     = 3'd3;
   localparam logic [2:0] S_RESPAWN   = 3'd4;
   localparam logic [2:0] S_GAMEOVER  = 3'd5;

   localparam int         FRM_W    = (FPS > 1) ? $clog2(FPS) : 1;
   localparam logic [FRM_W-1:0] FRM_LOAD = FRM_W'(FPS - 1);
   localparam logic [1:0] SEC_LOAD = 2'(COUNT_SECS);
   localparam logic [1:0] LIV_LOAD = 2'(LIVES_INIT);
   localparam logic [9:0] DIE_LOAD = 10'(DIE_FRAMES - 1);
   localparam logic [9:0] GO_LOAD  = 10'(GAMEOVER_FRAMES - 1);

   logic [2:0]       r_state;
   logic [1:0]       r_lives;
   logic [1:0]       r_sec;
   logic [FRM_W-1:0] r_frm;
   logic [9:0]       r_tmr;
   logic [7:0]       r_prev_key;
   logic             r_game_reset;
   logic [7:0]       r_keycode_out;
   logic [1:0]       r_cd_digit;
   logic             r_blink;

   logic             w_start_edge;
   logic [2:0]       w_nxt_state;
   logic [1:0]       w_nxt_lives;
   logic [1:0]       w_nxt_sec;
   logic [FRM_W-1:0] w_nxt_frm;
   logic [9:0]       w_nxt_tmr;

   // Enter held across a state entry gives no edge: the previous keycode must differ.
   assign w_start_edge = (keycode == START_KEY) && (r_prev_key != START_KEY);

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_lives = r_lives;
      w_nxt_sec   = r_sec;
      w_nxt_frm   = r_frm;
      w_nxt_tmr   = r_tmr;
      case (r_state)
         S_TITLE: begin
            if (w_start_edge) begin
               w_nxt_state = S_COUNTDOWN;
               w_nxt_lives = LIV_LOAD;
               w_nxt_sec   = SEC_LOAD;
               w_nxt_frm   = FRM_LOAD;
            end
         end
         S_COUNTDOWN: begin
            if (r_frm != '0) begin
               w_nxt_frm = r_frm - 1'b1;
            end else if (r_sec > 2'd1) begin
               w_nxt_sec = r_sec - 2'd1;
               w_nxt_frm = FRM_LOAD;
            end else begin
               w_nxt_state = S_PLAYING;
            end
         end
         S_PLAYING: begin
            if (over) begin
               w_nxt_state = S_DYING;
               w_nxt_tmr   = DIE_LOAD;
            end
         end
         S_DYING: begin
            if (r_tmr == 10'd0) begin
               if (r_lives <= 2'd1) begin
                  w_nxt_state = S_GAMEOVER;
                  w_nxt_lives = 2'd0;
                  w_nxt_tmr   = GO_LOAD;
               end else begin
                  w_nxt_state = S_RESPAWN;
                  w_nxt_lives = r_lives - 2'd1;
               end
            end else begin
               w_nxt_tmr = r_tmr - 10'd1;
            end
         end
         S_RESPAWN: begin
            w_nxt_state = S_COUNTDOWN;
            w_nxt_sec   = SEC_LOAD;
            w_nxt_frm   = FRM_LOAD;
         end
         S_GAMEOVER: begin
            if (w_start_edge || (r_tmr == 10'd0)) w_nxt_state = S_TITLE;
            else                                  w_nxt_tmr   = r_tmr - 10'd1;
         end
         default: begin
            w_nxt_state = S_TITLE;
            w_nxt_lives = LIV_LOAD;
            w_nxt_sec   = 2'd0;
            w_nxt_frm   = '0;
            w_nxt_tmr   = 10'd0;
         end
      endcase
   end

   // Outputs are registered from the next state so they always match round_state.
   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         r_state       <= S_TITLE;
         r_lives       <= LIV_LOAD;
         r_sec         <= 2'd0;
         r_frm         <= '0;
         r_tmr         <= 10'd0;
         r_prev_key    <= 8'd0;
         r_game_reset  <= 1'b1;
         r_keycode_out <= 8'd0;
         r_cd_digit    <= 2'd0;
         r_blink       <= 1'b0;
      end else begin
         r_state       <= w_nxt_state;
         r_lives       <= w_nxt_lives;
         r_sec         <= w_nxt_sec;
         r_frm         <= w_nxt_frm;
         r_tmr         <= w_nxt_tmr;
         r_prev_key    <= keycode;
         r_game_reset  <= (w_nxt_state == S_TITLE) || (w_nxt_state == S_RESPAWN) ||
                          (w_nxt_state == S_GAMEOVER);
         r_keycode_out <= (w_nxt_state == S_PLAYING) ? keycode : 8'd0;
         r_cd_digit    <= (w_nxt_state == S_COUNTDOWN) ? w_nxt_sec : 2'd0;
         r_blink       <= (w_nxt_state == S_DYING) ? w_nxt_tmr[3] : 1'b0;
      end
   end

   assign game_reset  = r_game_reset;
   assign keycode_out = r_keycode_out;
   assign lives       = r_lives;
   assign round_state = r_state;
   assign cd_digit    = r_cd_digit;
   assign blink       = r_blink;

endmodule
